// File: rtl/crtc_pkg.sv
// -----------------------------------------------------------------------------
// crtc_pkg
//   Shared definitions for the CGIA raster timing generator.
//   CRTC_W     : width of every dot/line counter and timing field
//   crtc_cnt_t : counter / timing-field type
// -----------------------------------------------------------------------------
package crtc_pkg;

    localparam int CRTC_W = 10;

    typedef logic [CRTC_W-1:0] crtc_cnt_t;

endpackage : crtc_pkg

// File: rtl/crtc_axis.sv
// -----------------------------------------------------------------------------
// crtc_axis
//   One raster axis: a counter that steps when enabled, wraps to zero after
//   reaching its programmed total, and drives a sync flag that rises when the
//   counter reaches sstart and falls when the counter returns to zero.
//   Used twice by crtc: horizontal (steps every dot) and vertical (steps on
//   the last dot of each line).
//
//   clk    in   1   clock, rising edge
//   rst_n  in   1   asynchronous active-low reset
//   en     in   1   step enable
//   total  in   W   last counter value before wrap
//   sstart in   W   counter value at which sync asserts
//   cnt    out  W   current counter value (registered)
//   nxt    out  W   value the counter will take on the next enabled step
//   wrap   out  1   counter is at total (next step returns to zero)
//   sync   out  1   sync flag (registered, matches cnt)
// -----------------------------------------------------------------------------
module crtc_axis
    import crtc_pkg::*;
#(
    parameter int W = CRTC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] total,
    input  logic [W-1:0] sstart,
    output logic [W-1:0] cnt,
    output logic [W-1:0] nxt,
    output logic         wrap,
    output logic         sync
);

    // Equality compare only: a counter already past total keeps counting
    // and rolls over through 2^W-1 without asserting wrap.
    assign wrap = (cnt == total);
    assign nxt  = wrap ? '0 : cnt + W'(1);

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values; the async reset sits in the sensitivity list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sync <= 1'b0;
        end else if (en) begin
            cnt <= nxt;
            // Clear has priority, so sstart==0 never raises sync.
            if (nxt == '0)
                sync <= 1'b0;
            else if (nxt == sstart)
                sync <= 1'b1;
        end
    end

endmodule : crtc_axis

// File: rtl/crtc.sv
// -----------------------------------------------------------------------------
// crtc
//   Raster timing generator for the CGIA video path. Produces dot/line
//   counters, HSYNC/VSYNC and horizontal/vertical display-enable windows from
//   programmable timing fields. All outputs are registered and each flag
//   corresponds to the x/y presented alongside it.
//
//   dotclk_i   in   1   dot clock, rising edge
//   reset_i    in   1   asynchronous active-low reset
//   htotal_i   in   W   last dot index of a scanline
//   vtotal_i   in   W   last line index of a frame
//   hsstart_i  in   W   dot index where HSYNC asserts
//   vsstart_i  in   W   line index where VSYNC asserts
//   hvstart_i  in   W   dot index where HDEN asserts
//   hvend_i    in   W   dot index where HDEN negates
//   vvstart_i  in   W   line whose last dot sets VDEN
//   vvend_i    in   W   line whose last dot clears VDEN
//   x_o, y_o   out  W   dot / line counters
//   hsync_o    out  1   horizontal sync, active high
//   vsync_o    out  1   vertical sync, active high
//   hden_o     out  1   horizontal display enable
//   vden_o     out  1   vertical display enable
// -----------------------------------------------------------------------------
module crtc
    import crtc_pkg::*;
#(
    parameter int W = CRTC_W
) (
    input  logic         dotclk_i,
    input  logic         reset_i,
    input  logic [W-1:0] htotal_i,
    input  logic [W-1:0] vtotal_i,
    input  logic [W-1:0] hsstart_i,
    input  logic [W-1:0] vsstart_i,
    input  logic [W-1:0] hvstart_i,
    input  logic [W-1:0] hvend_i,
    input  logic [W-1:0] vvstart_i,
    input  logic [W-1:0] vvend_i,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    output logic         hsync_o,
    output logic         vsync_o,
    output logic         hden_o,
    output logic         vden_o
);

    logic [W-1:0] h_nxt;
    logic         hwrap;
    logic [W-1:0] v_nxt_unused;
    logic         v_wrap_unused;

    crtc_axis #(.W(W)) u_haxis (
        .clk    (dotclk_i),
        .rst_n  (reset_i),
        .en     (1'b1),
        .total  (htotal_i),
        .sstart (hsstart_i),
        .cnt    (x_o),
        .nxt    (h_nxt),
        .wrap   (hwrap),
        .sync   (hsync_o)
    );

    // Vertical axis only advances on the last dot of a line.
    crtc_axis #(.W(W)) u_vaxis (
        .clk    (dotclk_i),
        .rst_n  (reset_i),
        .en     (hwrap),
        .total  (vtotal_i),
        .sstart (vsstart_i),
        .cnt    (y_o),
        .nxt    (v_nxt_unused),
        .wrap   (v_wrap_unused),
        .sync   (vsync_o)
    );

    // HDEN follows the dot the counter is moving to, so it lines up with x_o.
    // VDEN is sampled on the current line at line end: it therefore becomes
    // visible one line after vvstart/vvend, and a frame wrap leaves it alone.
    always_ff @(posedge dotclk_i or negedge reset_i) begin
        if (!reset_i) begin
            hden_o <= 1'b0;
            vden_o <= 1'b0;
        end else begin
            if (h_nxt == hvend_i)
                hden_o <= 1'b0;
            else if (h_nxt == hvstart_i)
                hden_o <= 1'b1;

            if (hwrap) begin
                if (y_o == vvend_i)
                    vden_o <= 1'b0;
                else if (y_o == vvstart_i)
                    vden_o <= 1'b1;
            end
        end
    end

endmodule : crtc

// File: tb/tb_crtc.sv
// -----------------------------------------------------------------------------
// tb_crtc
//   Self-checking bench for crtc: directed scenarios with expected values
//   taken from the raster windows, then a randomized run against a
//   line/frame reference model held in integer arithmetic.
// -----------------------------------------------------------------------------
module tb_crtc;

    localparam int W = 10;
    localparam int M = 1 << W;

    logic         dotclk_i = 1'b0;
    logic         reset_i  = 1'b0;
    logic [W-1:0] htotal_i, vtotal_i, hsstart_i, vsstart_i;
    logic [W-1:0] hvstart_i, hvend_i, vvstart_i, vvend_i;
    logic [W-1:0] x_o, y_o;
    logic         hsync_o, vsync_o, hden_o, vden_o;

    int n_cmp = 0;
    int n_err = 0;

    crtc #(.W(W)) dut (
        .dotclk_i  (dotclk_i),
        .reset_i   (reset_i),
        .htotal_i  (htotal_i),
        .vtotal_i  (vtotal_i),
        .hsstart_i (hsstart_i),
        .vsstart_i (vsstart_i),
        .hvstart_i (hvstart_i),
        .hvend_i   (hvend_i),
        .vvstart_i (vvstart_i),
        .vvend_i   (vvend_i),
        .x_o       (x_o),
        .y_o       (y_o),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o),
        .hden_o    (hden_o),
        .vden_o    (vden_o)
    );

    always #5 dotclk_i = ~dotclk_i;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge dotclk_i);
        #1;
    endtask

    task automatic set_timing(input int ht, input int vt, input int hs, input int vs,
                              input int hvs, input int hve, input int vvs, input int vve);
        htotal_i  = W'(ht);
        vtotal_i  = W'(vt);
        hsstart_i = W'(hs);
        vsstart_i = W'(vs);
        hvstart_i = W'(hvs);
        hvend_i   = W'(hve);
        vvstart_i = W'(vvs);
        vvend_i   = W'(vve);
    endtask

    // Leaves the DUT at x=0,y=0 with reset released, just after an edge.
    task automatic do_reset();
        reset_i = 1'b0;
        tick();
        reset_i = 1'b1;
    endtask

    task automatic test_reset();
        set_timing(799, 524, 656, 490, 0, 640, 0, 480);
        reset_i = 1'b0;
        tick();
        n_cmp++;
        if ({x_o, y_o, hsync_o, vsync_o, hden_o, vden_o} !== '0) begin
            n_err++;
            $display("FAIL reset_state: x=%0d y=%0d flags=%b%b%b%b, required all 0",
                     x_o, y_o, hsync_o, vsync_o, hden_o, vden_o);
        end
        reset_i = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_cmp++;
            if (x_o !== W'(i) || y_o !== '0) begin
                n_err++;
                $display("FAIL reset_release: x=%0d y=%0d, required x=%0d y=0", x_o, y_o, i);
            end
        end
        repeat (5) tick();
        // Asynchronous reset mid-line: no clock edge needed.
        reset_i = 1'b0;
        #2;
        n_cmp++;
        if (x_o !== '0 || y_o !== '0) begin
            n_err++;
            $display("FAIL reset_async: x=%0d y=%0d, required 0/0", x_o, y_o);
        end
        tick();
        n_cmp++;
        if (x_o !== '0) begin
            n_err++;
            $display("FAIL reset_hold: x=%0d, required 0", x_o);
        end
        reset_i = 1'b1;
    endtask

    task automatic test_wrap();
        int exp_y[3] = '{2, 3, 0};
        set_timing(799, 524, 656, 490, 0, 640, 0, 480);
        do_reset();
        tick();
        tick();
        n_cmp++;
        if (x_o !== W'(2)) begin
            n_err++;
            $display("FAIL wrap_pre: x=%0d, required 2", x_o);
        end
        htotal_i = W'(5);
        vtotal_i = W'(3);
        repeat (4) tick();
        n_cmp++;
        if (x_o !== '0 || y_o !== W'(1)) begin
            n_err++;
            $display("FAIL wrap_short_line: x=%0d y=%0d, required x=0 y=1", x_o, y_o);
        end
        for (int k = 0; k < 3; k++) begin
            repeat (6) tick();
            n_cmp++;
            if (x_o !== '0 || y_o !== W'(exp_y[k])) begin
                n_err++;
                $display("FAIL wrap_frame: x=%0d y=%0d, required x=0 y=%0d", x_o, y_o, exp_y[k]);
            end
        end
    endtask

    // Counter beyond a lowered htotal rolls through 2^W-1 without a line step.
    task automatic test_natural_wrap();
        set_timing(799, 524, 900, 900, 900, 900, 900, 900);
        do_reset();
        repeat (10) tick();
        htotal_i = W'(5);
        repeat (M - 10) tick();
        n_cmp++;
        if (x_o !== '0 || y_o !== '0) begin
            n_err++;
            $display("FAIL natural_wrap: x=%0d y=%0d, required x=0 y=0", x_o, y_o);
        end
        repeat (6) tick();
        n_cmp++;
        if (x_o !== '0 || y_o !== W'(1)) begin
            n_err++;
            $display("FAIL natural_wrap_next: x=%0d y=%0d, required x=0 y=1", x_o, y_o);
        end
    endtask

    task automatic test_hsync();
        set_timing(5, 3, 3, 900, 900, 900, 900, 900);
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            int  ex;
            logic eh;
            tick();
            ex = i % 6;
            eh = (ex >= 3);
            n_cmp++;
            if (x_o !== W'(ex) || hsync_o !== eh) begin
                n_err++;
                $display("FAIL hsync: x=%0d hsync=%b, required x=%0d hsync=%b", x_o, hsync_o, ex, eh);
            end
        end
    endtask

    task automatic test_vsync();
        set_timing(5, 3, 900, 2, 900, 900, 900, 900);
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            int  ey;
            logic ev;
            tick();
            ey = (i / 6) % 4;
            ev = (ey >= 2);
            n_cmp++;
            if (y_o !== W'(ey) || vsync_o !== ev) begin
                n_err++;
                $display("FAIL vsync: y=%0d vsync=%b, required y=%0d vsync=%b", y_o, vsync_o, ey, ev);
            end
        end
    endtask

    task automatic test_hden();
        set_timing(5, 3, 900, 900, 1, 4, 900, 900);
        do_reset();
        n_cmp++;
        if (hden_o !== 1'b0) begin
            n_err++;
            $display("FAIL hden_reset: hden=%b, required 0", hden_o);
        end
        for (int i = 1; i <= 12; i++) begin
            int  ex;
            logic eh;
            tick();
            ex = i % 6;
            eh = (ex >= 1 && ex < 4);
            n_cmp++;
            if (hden_o !== eh) begin
                n_err++;
                $display("FAIL hden: x=%0d hden=%b, required %b", ex, hden_o, eh);
            end
        end
    endtask

    task automatic test_vden();
        set_timing(5, 3, 900, 900, 900, 900, 0, 2);
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            int  ey;
            logic ev;
            tick();
            ey = (i / 6) % 4;
            ev = (ey == 1 || ey == 2);
            n_cmp++;
            if (vden_o !== ev) begin
                n_err++;
                $display("FAIL vden: x=%0d y=%0d vden=%b, required %b", i % 6, ey, vden_o, ev);
            end
        end
    endtask

    // Coincident set/clear: hsstart==0, hvstart==hvend, vvstart==vvend.
    task automatic test_priority();
        set_timing(5, 3, 0, 0, 2, 2, 1, 1);
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            tick();
            n_cmp++;
            if ({hsync_o, vsync_o, hden_o, vden_o} !== 4'b0000) begin
                n_err++;
                $display("FAIL priority: hs=%b vs=%b hd=%b vd=%b, required all 0",
                         hsync_o, vsync_o, hden_o, vden_o);
            end
        end
    endtask

    task automatic randomize_timing();
        int ht, vt;
        ht = $urandom_range(12, 2);
        vt = $urandom_range(6, 2);
        set_timing(ht, vt, $urandom_range(ht + 1, 0), $urandom_range(vt + 1, 0),
                   $urandom_range(ht + 1, 0), $urandom_range(ht + 1, 0),
                   $urandom_range(vt + 1, 0), $urandom_range(vt + 1, 0));
    endtask

    // Reference model: position advances one dot per edge within a line of
    // htotal+1 dots (or rolls modulo 2^W when past the end); each window flag
    // is an edge-triggered set/clear against the dot/line being entered, with
    // VDEN judged on the line being left.
    task automatic test_random();
        int   mx, my, nx, ny;
        logic mhs, mvs, mhd, mvd;
        bit   eol;
        randomize_timing();
        do_reset();
        mx = 0; my = 0; mhs = 0; mvs = 0; mhd = 0; mvd = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 249)
                randomize_timing();
            else if ($urandom_range(29, 0) == 0)
                hvstart_i = W'($urandom_range(int'(htotal_i), 0));
            else if ($urandom_range(199, 0) == 0)
                htotal_i = W'($urandom_range(3, 1));

            eol = (mx == int'(htotal_i));
            nx  = eol ? 0 : (mx + 1) % M;
            ny  = !eol ? my : (my == int'(vtotal_i)) ? 0 : (my + 1) % M;
            if (nx == 0)                    mhs = 1'b0;
            else if (nx == int'(hsstart_i)) mhs = 1'b1;
            if (nx == int'(hvend_i))        mhd = 1'b0;
            else if (nx == int'(hvstart_i)) mhd = 1'b1;
            if (eol) begin
                if (ny == 0)                    mvs = 1'b0;
                else if (ny == int'(vsstart_i)) mvs = 1'b1;
                if (my == int'(vvend_i))        mvd = 1'b0;
                else if (my == int'(vvstart_i)) mvd = 1'b1;
            end
            mx = nx;
            my = ny;

            tick();
            n_cmp++;
            if (x_o !== W'(mx) || y_o !== W'(my)) begin
                n_err++;
                $display("FAIL rand_pos c=%0d: x=%0d y=%0d, required x=%0d y=%0d", c, x_o, y_o, mx, my);
            end
            n_cmp++;
            if ({hsync_o, vsync_o, hden_o, vden_o} !== {mhs, mvs, mhd, mvd}) begin
                n_err++;
                $display("FAIL rand_flags c=%0d x=%0d y=%0d: hs/vs/hd/vd=%b%b%b%b, required %b%b%b%b",
                         c, mx, my, hsync_o, vsync_o, hden_o, vden_o, mhs, mvs, mhd, mvd);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wrap();
        test_natural_wrap();
        test_hsync();
        test_vsync();
        test_hden();
        test_vden();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_crtc
